// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDUOp control encodings and opcode decode helpers
package mdu_pkg;

    // MDUOp encodings, kept beside the ALUOp codes in the control decode
    localparam logic [2:0] MDU_NOP   = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;

    // True for the four iterative operations that occupy the unit
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_divide(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - conditional two's-complement negate
// Ports:
//   din  : value to condition
//   neg  : 1 = output -din, 0 = pass din through
//   dout : conditioned value
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - sequential multiply/divide unit with architectural HI/LO
// Ports:
//   clk, rstn  : rising-edge clock, asynchronous active-low reset
//   start      : launch MDUOp; only sampled while busy is low
//   MDUOp      : MULT/MULTU/DIV/DIVU/MTHI/MTLO/NOP
//   A, B       : rs / rt operands
//   busy       : mul/div in flight (front-end stall)
//   done       : one-cycle pulse when HI/LO first show a mul/div result
//   HI, LO     : architectural result registers
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Operation latches
    logic               op_div;     // divide (else multiply)
    logic               op_dz;      // divide by zero: commit raw A, all-ones LO
    logic               neg_q;      // negate product / quotient at fixup
    logic               neg_r;      // negate remainder at fixup (dividend sign)
    logic [WIDTH-1:0]   dvsr;       // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] prod;       // multiply accumulator; low half holds the shifting multiplier
    logic [WIDTH-1:0]   quo;        // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   rem;        // settled partial remainder (always < divisor)

    logic accept, op_md, op_dv, op_sg, dz;

    assign accept = start & ~busy_q;
    assign op_md  = is_muldiv(MDUOp);
    assign op_dv  = is_divide(MDUOp);
    assign op_sg  = is_signed_op(MDUOp);
    assign dz     = op_dv && (B == '0);

    // Operand absolute values for the signed forms
    logic [WIDTH-1:0] a_abs, b_abs;

    mdu_signfix #(.W(WIDTH)) u_abs_a (.din(A), .neg(op_sg & A[WIDTH-1]), .dout(a_abs));
    mdu_signfix #(.W(WIDTH)) u_abs_b (.din(B), .neg(op_sg & B[WIDTH-1]), .dout(b_abs));

    // Result sign correction
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.din(prod), .neg(neg_q), .dout(prod_fix));
    mdu_signfix #(.W(WIDTH))   u_fix_quo  (.din(quo),  .neg(neg_q), .dout(quo_fix));
    mdu_signfix #(.W(WIDTH))   u_fix_rem  (.din(rem),  .neg(neg_r), .dout(rem_fix));

    // Shift-add step: add multiplicand if the current multiplier bit is set,
    // then shift the whole accumulator right; the carry lands in the top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nxt;

    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? dvsr : '0)};
    assign prod_nxt = {mul_sum, prod[WIDTH-1:1]};

    // Restoring divide step on the 33-bit partial remainder. When the trial
    // subtraction succeeds the difference is below the divisor, so a
    // WIDTH-bit subtract is exact.
    logic [WIDTH:0]   div_shift;
    logic             qbit;
    logic [WIDTH-1:0] div_diff, rem_nxt;

    assign div_shift = {rem, quo[WIDTH-1]};
    assign qbit      = (div_shift >= {1'b0, dvsr});
    assign div_diff  = div_shift[WIDTH-1:0] - dvsr;
    assign rem_nxt   = qbit ? div_diff : div_shift[WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && op_md) state_nxt = dz ? S_FIXUP : S_RUN;
            S_RUN:   if (cnt == CW'(WIDTH-1)) state_nxt = S_FIXUP;
            S_FIXUP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            op_div <= 1'b0;
            op_dz  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvsr   <= '0;
            prod   <= '0;
            quo    <= '0;
            rem    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_md) begin
                            busy_q <= 1'b1;
                            cnt    <= '0;
                            op_div <= op_dv;
                            op_dz  <= dz;
                            neg_q  <= op_sg & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r  <= op_sg & op_dv & A[WIDTH-1];
                            dvsr   <= op_dv ? b_abs : a_abs;
                            prod   <= {{WIDTH{1'b0}}, b_abs};
                            // divide by zero returns the raw dividend in HI
                            quo    <= dz ? A : a_abs;
                            rem    <= '0;
                        end else if (MDUOp == MDU_MTHI) begin
                            hi_q <= A;
                        end else if (MDUOp == MDU_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op_div) begin
                        rem <= rem_nxt;
                        quo <= {quo[WIDTH-2:0], qbit};
                    end else begin
                        prod <= prod_nxt;
                    end
                end
                S_FIXUP: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (op_dz) begin
                        hi_q <= quo;
                        lo_q <= '1;
                    end else if (op_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hi_m, lo_m;

    mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          inj;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Architectural reference: plain integer arithmetic on the operands
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
        logic [63:0] p;
        longint x, y, q, r;
        lat = 0;
        case (op)
            MDU_MULT: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                p = 64'(x * y);
                hi = p[63:32]; lo = p[31:0]; lat = 33;
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                hi = p[63:32]; lo = p[31:0]; lat = 33;
            end
            MDU_DIV, MDU_DIVU: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    if (op == MDU_DIV) begin
                        x = longint'($signed(a));
                        y = longint'($signed(b));
                    end else begin
                        x = longint'({32'd0, a});
                        y = longint'({32'd0, b});
                    end
                    q = x / y;
                    r = x % y;
                    lo = 32'(q); hi = 32'(r); lat = 33;
                end
            end
            MDU_MTHI: hi = a;
            MDU_MTLO: lo = a;
            default: ;
        endcase
    endtask

    // Issue one op and follow it to completion. inj>0 pulses a MTLO start
    // so that the edge E<inj> samples it while the unit is busy.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_lat, input int inj);
        logic [31:0] old_hi, old_lo;
        int  cycles;
        bit  stable, early_done, md;
        md = is_muldiv(op);
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a; B = b;
        old_hi = HI; old_lo = LO;
        @(negedge clk);
        start = 1'b0; MDUOp = MDU_NOP; A = $urandom; B = $urandom;
        cycles = 0; stable = 1'b1; early_done = 1'b0;
        while (busy && cycles < 200) begin
            if (HI !== old_hi || LO !== old_lo) stable = 1'b0;
            if (done) early_done = 1'b1;
            cycles++;
            if (cycles == inj) begin
                start = 1'b1; MDUOp = MDU_MTLO; A = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; MDUOp = MDU_NOP;
        end
        chk($sformatf("%s busy_cycles", name), 32'(cycles), 32'(exp_lat));
        chk($sformatf("%s done", name), {31'd0, done}, {31'd0, md});
        chk($sformatf("%s HI", name), HI, exp_hi);
        chk($sformatf("%s LO", name), LO, exp_lo);
        if (md) begin
            chk($sformatf("%s hilo_stable", name), {31'd0, stable}, 32'd1);
            chk($sformatf("%s early_done", name), {31'd0, early_done}, 32'd0);
            @(negedge clk);
            chk($sformatf("%s done_pulse_end", name), {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        bit          seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat, sel;

        vecs[0] = '{"mult_neg3x7",   MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, -1};
        vecs[1] = '{"multu_max",     MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1};
        vecs[2] = '{"div_neg7by2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1};
        vecs[3] = '{"div_overflow",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, -1};
        vecs[4] = '{"divu_by_zero",  MDU_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1,  -1};
        vecs[5] = '{"mthi",          MDU_MTHI,  32'h1234_5678, 32'd9,         32'h1234_5678, 32'hFFFF_FFFF, 0,  -1};
        vecs[6] = '{"mtlo",          MDU_MTLO,  32'hCAFE_F00D, 32'd9,         32'h1234_5678, 32'hCAFE_F00D, 0,  -1};
        vecs[7] = '{"nop",           MDU_NOP,   32'h1111_1111, 32'd9,         32'h1234_5678, 32'hCAFE_F00D, 0,  -1};
        vecs[8] = '{"undef_op",      3'b111,    32'h2222_2222, 32'd9,         32'h1234_5678, 32'hCAFE_F00D, 0,  -1};
        vecs[9] = '{"divu_100by7",   MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 5};

        rstn = 1'b0; start = 1'b0; MDUOp = MDU_NOP; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].inj);

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1; MDUOp = MDU_MULT; A = 32'hFFFF_FFFD; B = 32'd7;
        @(negedge clk);
        start = 1'b0; MDUOp = MDU_NOP;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst HI", HI, 32'd0);
        chk("midrst LO", LO, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) rstn = 1'b1;
            if (done || busy) seen = 1'b1;
        end
        chk("midrst no_resume", {31'd0, seen}, 32'd0);
        do_op("multu_3x5_after_rst", MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33, -1);

        // Randomised ops against the arithmetic model
        hi_m = HI;
        lo_m = LO;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) op = 3'($urandom_range(1, 4));
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            model(op, a, b, hi_m, lo_m, lat);
            do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, hi_m, lo_m, lat, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
